// File: rtl/gals_pkg.sv
// rtl/gals_pkg.sv - shared types and constants for the GALS producer/consumer pair
package gals_pkg;
   localparam int DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      REQ,
      RELEASE,
      DONE,
      ERROR
   } state_e;
endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchroniser for a single asynchronous level
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);
   // Fewer than two flops gives no metastability settling time.
   localparam int N = (STAGES < 2) ? 2 : STAGES;

   logic [N-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[N-2:0], d_i};
      end
   end

   assign q_o = sync_q[N-1];
endmodule

// File: rtl/gals_producer_ctrl.sv
// rtl/gals_producer_ctrl.sv - producer controller: fetches timer samples, ships them over 4-phase req/ack
module gals_producer_ctrl
   import gals_pkg::*;
#(
   parameter int MAX_SAMPLES = 0,
   parameter int ACK_TIMEOUT = 1024,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clock_1,
   input  logic              reset,
   input  logic              run,
   input  logic              clear_err,
   input  logic              t_valid,
   input  logic [DATA_W-1:0] t_out,
   input  logic              ack,
   output logic              t_en,
   output logic              req,
   output logic [DATA_W-1:0] data_out,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       sent_count
);
   localparam logic [15:0] MAX_CNT  = 16'(MAX_SAMPLES);
   localparam logic [31:0] TMO_LAST = 32'(ACK_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic [15:0]       sent_q, sent_d;
   logic [31:0]       tmo_q, tmo_d;
   logic              ack_s;
   logic              timeout_hit;

   sync_ff #(
      .STAGES(SYNC_STAGES)
   ) u_ack_sync (
      .clk_i (clock_1),
      .rst_ni(reset),
      .d_i   (ack),
      .q_o   (ack_s)
   );

   assign timeout_hit = (ACK_TIMEOUT != 0) && (tmo_q == TMO_LAST);

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      sent_d  = sent_q;
      unique case (state_q)
         IDLE: begin
            if (run) state_d = FETCH;
         end
         FETCH: begin
            if (t_valid) begin
               data_d  = t_out;
               state_d = REQ;
            end
         end
         REQ: begin
            // A stale ack still high on entry is accepted; RELEASE makes the consumer drop it.
            if (ack_s)            state_d = RELEASE;
            else if (timeout_hit) state_d = ERROR;
         end
         RELEASE: begin
            if (!ack_s) begin
               sent_d = sent_q + 16'd1;
               if ((MAX_SAMPLES != 0) && (sent_d == MAX_CNT)) state_d = DONE;
               else if (run)                                   state_d = FETCH;
               else                                            state_d = IDLE;
            end else if (timeout_hit) begin
               state_d = ERROR;
            end
         end
         DONE: begin
            if (!run) state_d = IDLE;
         end
         ERROR: begin
            if (clear_err) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Every entry into REQ or RELEASE is a state change, so the count restarts there.
      if ((state_d == state_q) && ((state_q == REQ) || (state_q == RELEASE))) begin
         tmo_d = tmo_q + 32'd1;
      end else begin
         tmo_d = '0;
      end
   end

   always_ff @(posedge clock_1 or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         data_q  <= '0;
         sent_q  <= '0;
         tmo_q   <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         sent_q  <= sent_d;
         tmo_q   <= tmo_d;
      end
   end

   assign t_en       = (state_q == FETCH);
   assign req        = (state_q == REQ);
   assign busy       = (state_q == FETCH) || (state_q == REQ) || (state_q == RELEASE);
   assign done       = (state_q == DONE);
   assign err        = (state_q == ERROR);
   assign data_out   = data_q;
   assign sent_count = sent_q;
endmodule
